// File: rtl/led_mode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_mode_pkg : mode codes, press-FSM states and mode helper functions |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package led_mode_pkg;

    localparam int MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_OFF = 4'd0;
    localparam logic [MODE_W-1:0] MODE_1   = 4'd1;
    localparam logic [MODE_W-1:0] MODE_2   = 4'd2;
    localparam logic [MODE_W-1:0] MODE_3   = 4'd3;
    localparam logic [MODE_W-1:0] MODE_4   = 4'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } press_state_t;

    // Short-press step: off and the top mode both land on mode 1, so 0 is never produced.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] mode,
                                                    input logic [MODE_W-1:0] max_mode);
        return (mode >= max_mode) ? MODE_1 : mode + 1'b1;
    endfunction

    function automatic logic [7:0] mode_to_led(input logic [MODE_W-1:0] mode);
        logic [7:0] led;
        led = 8'h00;
        if (mode != MODE_OFF && mode <= 4'd8) begin
            led = 8'h01 << (mode - 4'd1);
        end
        return led;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce : 2-FF synchroniser, debouncer, press/release pulses    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
    // The level is accepted on the cycle that would make the count reach DEBOUNCE_CYCLES,
    // so the counter itself never needs to hold more than DEBOUNCE_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q,    sync_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             key_db_q,  key_db_d;
    logic             db_prev_q, db_prev_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    always_comb begin
        sync_d    = {sync_q[0], i_key_n};
        cnt_d     = '0;
        key_db_d  = key_db_q;
        db_prev_d = key_db_q;
        press_d   = db_prev_q & ~key_db_q;
        release_d = ~db_prev_q & key_db_q;
        if (sync_q[1] != key_db_q) begin
            if (cnt_q == CNT_LAST) begin
                key_db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            key_db_q  <= 1'b1;
            db_prev_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            key_db_q  <= key_db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_press   = press_q;
    assign o_release = release_q;

endmodule
`default_nettype wire

// File: rtl/mode_key_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mode_key_controller : push-button mode stepper for the LED selector  |
// | MODE_LONGPRESS_EN compiles in the long-press-to-off feature.         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mode_key_controller
    import led_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int MODE_MAX        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_n,
    output logic [MODE_W-1:0] mode_select,
    output logic [7:0]        led_select,
    output logic              mode_changed
);

    localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(MODE_MAX);

    logic press;
    logic release_p;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_n   (key_n),
        .o_press   (press),
        .o_release (release_p)
    );

    press_state_t      state_q,   state_d;
    logic [MODE_W-1:0] mode_q,    mode_d;
    logic [7:0]        led_q,     led_d;
    logic              changed_q, changed_d;

`ifdef MODE_LONGPRESS_EN
    localparam int              HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
`ifdef MODE_LONGPRESS_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PRESSED;
`ifdef MODE_LONGPRESS_EN
                    // The press-pulse cycle is the first counted hold cycle.
                    hold_d  = HOLD_W'(1);
`endif
                end
            end
            PRESSED: begin
                if (release_p) begin
                    state_d = IDLE;
                    mode_d  = next_mode(mode_q, MODE_TOP);
                end
`ifdef MODE_LONGPRESS_EN
                else begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                    if (hold_d == HOLD_MAX) begin
                        state_d = LONG;
                        mode_d  = MODE_OFF;
                    end
                end
`endif
            end
`ifdef MODE_LONGPRESS_EN
            LONG: begin
                if (release_p) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        led_d     = mode_to_led(mode_d);
        changed_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_OFF;
            led_q     <= 8'h00;
            changed_q <= 1'b0;
`ifdef MODE_LONGPRESS_EN
            hold_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
            changed_q <= changed_d;
`ifdef MODE_LONGPRESS_EN
            hold_q    <= hold_d;
`endif
        end
    end

    assign mode_select  = mode_q;
    assign led_select   = led_q;
    assign mode_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_key_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mode_key_controller : directed scoreboard bench for the mode key  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mode_key_controller;

    localparam int DEB  = 8;
    localparam int LONG = 64;
    localparam int MMAX = 4;
    localparam int LAT  = DEB + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] mode_select;
    logic [7:0] led_select;
    logic       mode_changed;

    int n_eval    = 0;
    int n_fail    = 0;
    int chg_count = 0;

    logic [3:0] model_mode = 4'd0;

    typedef struct packed {
        logic [3:0] mode;
        logic [7:0] led;
    } exp_t;

    exp_t sb[$];

    mode_key_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .MODE_MAX       (MMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_n        (key_n),
        .mode_select  (mode_select),
        .led_select   (led_select),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mode_changed) chg_count++;
    end

    function automatic logic [3:0] model_next(input logic [3:0] m);
        return (m >= 4'(MMAX)) ? 4'd1 : m + 4'd1;
    endfunction

    function automatic logic [7:0] model_led(input logic [3:0] m);
        logic [7:0] l;
        l = 8'h00;
        if (m >= 4'd1 && m <= 4'd8) l[m - 4'd1] = 1'b1;
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hold(input int n);
        @(negedge clk);
        key_n = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after the raw release edge.
    task automatic check_advance(input string tag);
        exp_t e;
        int   lat;
        model_mode = model_next(model_mode);
        sb.push_back('{mode: model_mode, led: model_led(model_mode)});
        lat = -1;
        for (int c = 1; c <= 3 * LAT; c++) begin
            @(posedge clk);
            #1;
            if (mode_changed) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, LAT);
        e = sb.pop_front();
        check({tag, " mode"}, mode_select, e.mode);
        check({tag, " led"}, led_select, e.led);
        @(posedge clk);
        #1;
        check({tag, " pulse width"}, mode_changed, 1'b0);
    endtask

    task automatic short_press(input string tag, input int hold);
        int c0;
        c0 = chg_count;
        press_hold(hold);
        check({tag, " quiet while held"}, chg_count, c0);
        key_n = 1'b1;
        check_advance(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int first;

        #1 rst_n = 1'b0;
        idle(3);
        check("reset mode", mode_select, 4'd0);
        check("reset led", led_select, 8'h00);
        check("reset changed", mode_changed, 1'b0);
        rst_n = 1'b1;
        idle(5);
        check("idle mode", mode_select, 4'd0);

        for (int i = 1; i <= 5; i++) begin
            short_press($sformatf("short%0d", i), 20);
        end

        // Bouncy release: glitches shorter than the debounce window must be ignored.
        c0 = chg_count;
        press_hold(20);
        key_n = 1'b1; idle(5);
        key_n = 1'b0; idle(5);
        key_n = 1'b1; idle(5);
        key_n = 1'b0; idle(5);
        key_n = 1'b1;
        check("bounce quiet", chg_count, c0);
        check_advance("bounce");

        short_press("to3", 20);

        // Long hold of 100 cycles from mode 3.
        c0    = chg_count;
        first = -1;
        @(negedge clk);
        key_n = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (mode_changed && first < 0) first = c;
        end
        @(negedge clk);
        key_n = 1'b1;
`ifdef MODE_LONGPRESS_EN
        check("long edge", first, DEB + 2 + LONG);
        check("long pulses", chg_count - c0, 1);
        check("long mode", mode_select, 4'd0);
        check("long led", led_select, 8'h00);
        model_mode = 4'd0;
        c0 = chg_count;
        idle(3 * LAT);
        check("long release quiet", chg_count, c0);
        check("long release mode", mode_select, 4'd0);
`else
        check("hold no change", first, -1);
        check("hold mode", mode_select, 4'd3);
        check_advance("long off");
`endif

        short_press("pre_rst_a", 20);
        short_press("pre_rst_b", 20);
        check("mode before reset", mode_select, 4'd2);

        // Reset mid-hold, key kept down through reset release.
        @(negedge clk);
        key_n = 1'b0;
        idle(30);
        rst_n = 1'b0;
        #1;
        check("midhold rst mode", mode_select, 4'd0);
        check("midhold rst led", led_select, 8'h00);
        check("midhold rst changed", mode_changed, 1'b0);
        model_mode = 4'd0;
        idle(3);
        rst_n = 1'b1;
        c0 = chg_count;
        idle(20);
        check("post rst quiet", chg_count, c0);
        check("post rst mode", mode_select, 4'd0);
        key_n = 1'b1;
        check_advance("post rst");

        short_press("to2", 20);
        short_press("to3b", 20);
        short_press("to4", 20);
        short_press("wrap", 20);

        c0 = chg_count;
        idle(20);
        check("tail quiet", chg_count, c0);
        check("tail mode", mode_select, 4'd1);
        check("tail led", led_select, 8'h01);
        check("scoreboard empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
